// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and defaults for the Fibonacci stream checker
package fib_pkg;

  // Checker phases: two seed captures, then per-term prediction and compare.
  typedef enum logic [1:0] {
    SEED0 = 2'd0,
    SEED1 = 2'd1,
    TRACK = 2'd2
  } fib_state_t;

  // These defaults are shared with the generator bench.
  localparam int WIDTH_DEF    = 10;
  localparam int LOCK_LEN_DEF = 4;
  localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/fib_predictor.sv
// rtl/fib_predictor.sv - two-term history and modulo-2^WIDTH next-term predictor
//
// Keeps the last two accepted terms and the prediction for the next term.
//   clk        in   1      clock
//   reset      in   1      synchronous, active-high reset; clears history and prediction
//   load_seed0 in   1      prev2 <= data, prediction <= 0 (initial seed or re-seed after error)
//   load_seed1 in   1      prev1 <= data, prediction <= prev2 + data
//   advance    in   1      shift history by one term, prediction <= prev1 + data
//   data       in   WIDTH  term being accepted
//   expected   out  WIDTH  prediction for the next term
module fib_predictor #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_seed0,
  input  logic             load_seed1,
  input  logic             advance,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] expected
);

  logic [WIDTH-1:0] prev1;
  logic [WIDTH-1:0] prev2;
  logic [WIDTH-1:0] seed_sum;
  logic [WIDTH-1:0] track_sum;

  // Sums are truncated to WIDTH bits; the carry out is deliberately dropped.
  assign seed_sum  = prev2 + data;
  assign track_sum = prev1 + data;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev1    <= '0;
      prev2    <= '0;
      expected <= '0;
    end else if (load_seed0) begin
      prev2    <= data;
      expected <= '0;
    end else if (load_seed1) begin
      prev1    <= data;
      expected <= seed_sum;
    end else if (advance) begin
      prev2    <= prev1;
      prev1    <= data;
      expected <= track_sum;
    end
  end

endmodule

// File: rtl/fibonacci_checker.sv
// rtl/fibonacci_checker.sv - in-system integrity monitor for a Fibonacci term stream
//
// Self-seeds from the first two valid terms, then checks every further term against
// the modulo-2^WIDTH sum of the previous two. Locks after LOCK_LEN consecutive matches
// and re-seeds from the offending term after a mismatch.
//   clk        in   1      clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      in_data carries a term (always accepted)
//   in_data    in   WIDTH  observed term
//   clear      in   1      clears err_sticky and both counters; does not re-seed
//   locked     out  1      LOCK_LEN or more consecutive matches since the last seed
//   err_pulse  out  1      last accepted term mismatched (one cycle)
//   err_sticky out  1      any mismatch since clear/reset
//   expected   out  WIDTH  prediction for the next term (0 while seeding)
//   match_cnt  out  CNT_W  matching terms, saturating
//   err_cnt    out  CNT_W  mismatching terms, saturating
module fibonacci_checker
  import fib_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int LOCK_LEN = LOCK_LEN_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_LEN);

  fib_state_t       state;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_inc;
  logic             hit;
  logic             miss;
  logic [CNT_W-1:0] match_base;
  logic [CNT_W-1:0] err_base;

  assign hit     = in_valid && (state == TRACK) && (in_data == expected);
  assign miss    = in_valid && (state == TRACK) && (in_data != expected);
  assign run_inc = run + 1'b1;

  // clear takes effect first, so a same-cycle term counts from zero.
  assign match_base = clear ? '0 : match_cnt;
  assign err_base   = clear ? '0 : err_cnt;

  // A mismatching term is reloaded as the first seed, so re-seeding needs only one more term.
  fib_predictor #(.WIDTH(WIDTH)) u_predictor (
    .clk        (clk),
    .reset      (reset),
    .load_seed0 (in_valid && ((state == SEED0) || miss)),
    .load_seed1 (in_valid && (state == SEED1)),
    .advance    (hit),
    .data       (in_data),
    .expected   (expected)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEED0;
      run        <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      match_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      err_pulse  <= miss;
      err_sticky <= miss || (err_sticky && !clear);
      match_cnt  <= (hit && (match_base != '1)) ? match_base + 1'b1 : match_base;
      err_cnt    <= (miss && (err_base != '1)) ? err_base + 1'b1 : err_base;

      if (in_valid) begin
        case (state)
          SEED0: state <= SEED1;
          SEED1: state <= TRACK;
          TRACK: begin
            if (miss) begin
              state  <= SEED1;
              run    <= '0;
              locked <= 1'b0;
            end else begin
              // run parks at LOCK_LEN so it never wraps back below the lock threshold.
              if (run != LOCK_RUN) run <= run_inc;
              if (run_inc == LOCK_RUN) locked <= 1'b1;
            end
          end
          default: state <= SEED0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_checker.sv
// tb/tb_fibonacci_checker.sv - directed-vector bench for fibonacci_checker
module tb_fibonacci_checker;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             clear;

  logic             locked, err_pulse, err_sticky;
  logic [WIDTH-1:0] expected;
  logic [15:0]      match_cnt, err_cnt;

  logic             s_locked, s_err_pulse, s_err_sticky;
  logic [WIDTH-1:0] s_expected;
  logic [1:0]       s_match_cnt, s_err_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit pulse_seen;

  always #5 clk = ~clk;

  fibonacci_checker #(.WIDTH(WIDTH), .LOCK_LEN(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .expected   (expected),
    .match_cnt  (match_cnt),
    .err_cnt    (err_cnt)
  );

  fibonacci_checker #(.WIDTH(WIDTH), .LOCK_LEN(4), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .clear      (clear),
    .locked     (s_locked),
    .err_pulse  (s_err_pulse),
    .err_sticky (s_err_sticky),
    .expected   (s_expected),
    .match_cnt  (s_match_cnt),
    .err_cnt    (s_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic c, input logic r);
    reset    = r;
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    #1;
    if (err_pulse) pulse_seen = 1'b1;
    reset    = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  int fib1[7]  = '{0, 1, 1, 2, 3, 5, 8};
  int fib2[10] = '{13, 21, 34, 55, 89, 144, 233, 377, 610, 987};
  logic [WIDTH-1:0] held;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;

    // reset state
    step(1'b0, '0, 1'b0, 1'b1);
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_sticky", err_sticky, 0);
    check("rst_expected", expected, 0);
    check("rst_match_cnt", match_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);

    // 1: clean start 0,1,1,2,3,5,8
    pulse_seen = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(fib1[i]), 1'b0, 1'b0);
    check("s1_locked_after_3", locked, 0);
    step(1'b1, WIDTH'(fib1[5]), 1'b0, 1'b0);
    check("s1_locked_after_4", locked, 1);
    step(1'b1, WIDTH'(fib1[6]), 1'b0, 1'b0);
    check("s1_no_pulse", pulse_seen, 0);
    check("s1_locked", locked, 1);
    check("s1_match_cnt", match_cnt, 5);
    check("s1_expected", expected, 13);
    check("s1_err_cnt", err_cnt, 0);
    check("s1_sat_match_cnt", s_match_cnt, 3);

    // 2: run through 987, then the wrapped term 1597 mod 1024 = 573
    for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(fib2[i]), 1'b0, 1'b0);
    step(1'b1, 10'd573, 1'b0, 1'b0);
    check("s2_no_pulse", pulse_seen, 0);
    check("s2_match_cnt", match_cnt, 16);
    check("s2_expected", expected, 536);
    check("s2_locked", locked, 1);
    check("s2_sat_match_cnt", s_match_cnt, 3);

    // 3: error after lock and re-seed from the bad term
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, WIDTH'(fib1[i]), 1'b0, 1'b0);
    step(1'b1, 10'd21, 1'b0, 1'b0);
    check("s3_err_pulse", err_pulse, 1);
    check("s3_err_sticky", err_sticky, 1);
    check("s3_locked", locked, 0);
    check("s3_err_cnt", err_cnt, 1);
    check("s3_expected_reseed", expected, 0);
    check("s3_match_cnt", match_cnt, 5);
    step(1'b1, 10'd34, 1'b0, 1'b0);
    check("s3_pulse_drop", err_pulse, 0);
    check("s3_expected_34", expected, 55);
    step(1'b1, 10'd55, 1'b0, 1'b0);
    check("s3_match_55", match_cnt, 6);
    step(1'b1, 10'd89, 1'b0, 1'b0);
    check("s3_match_89", match_cnt, 7);
    check("s3_expected_89", expected, 144);
    check("s3_err_cnt_held", err_cnt, 1);
    check("s3_sticky_held", err_sticky, 1);

    // 5: clear with a mismatch, then clear with a match
    step(1'b1, 10'd100, 1'b1, 1'b0);
    check("s5_err_sticky", err_sticky, 1);
    check("s5_err_cnt", err_cnt, 1);
    check("s5_match_cnt", match_cnt, 0);
    check("s5_err_pulse", err_pulse, 1);
    step(1'b1, 10'd1, 1'b0, 1'b0);
    check("s5_expected", expected, 101);
    step(1'b1, 10'd101, 1'b1, 1'b0);
    check("s5_clear_match_cnt", match_cnt, 1);
    check("s5_clear_err_cnt", err_cnt, 0);
    check("s5_clear_sticky", err_sticky, 0);

    // 4: scenario 1 with a gap after every term
    step(1'b0, '0, 1'b0, 1'b1);
    pulse_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, WIDTH'(fib1[i]), 1'b0, 1'b0);
      held = expected;
      step(1'b0, 10'h3ff, 1'b0, 1'b0);
      check("s4_gap_hold", expected, held);
    end
    check("s4_no_pulse", pulse_seen, 0);
    check("s4_locked", locked, 1);
    check("s4_match_cnt", match_cnt, 5);
    check("s4_expected", expected, 13);
    check("s4_err_cnt", err_cnt, 0);

    // 6: reset in TRACK with a valid term present
    step(1'b1, 10'd500, 1'b0, 1'b1);
    check("s6_locked", locked, 0);
    check("s6_expected", expected, 0);
    check("s6_match_cnt", match_cnt, 0);
    check("s6_err_cnt", err_cnt, 0);
    check("s6_err_sticky", err_sticky, 0);
    check("s6_err_pulse", err_pulse, 0);
    step(1'b1, 10'd5, 1'b0, 1'b0);
    check("s6_seed0_expected", expected, 0);
    step(1'b1, 10'd5, 1'b0, 1'b0);
    check("s6_seed1_expected", expected, 10);
    check("s6_seed_uncounted", match_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
